// File: rtl/sub_tc_16_16_serial.sv
// ============================================================================
// Module   : sub_tc_16_16_serial
// Brief    : Bit-serial two's-complement subtractor, diff = a - b, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_tc_16_16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [WIDTH:0] r_a;
  logic [WIDTH:0] r_nb;
  logic [WIDTH:0] r_shift;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          w_sum;
  logic          w_cout;
  logic          w_last;

  // Single full-adder slice working on the current LSBs of the operand shifters
  assign w_sum  = r_a[0] ^ r_nb[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_nb[0]) | (r_a[0] & r_carry) | (r_nb[0] & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_nb    <= '0;
      r_shift <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Sign-extend before inverting so b = -2^(WIDTH-1) stays exact
            r_a     <= {a[WIDTH-1], a};
            r_nb    <= ~{b[WIDTH-1], b};
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_nb    <= r_nb >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          r_shift <= {w_sum, r_shift[WIDTH:1]};
          if (w_last) begin
            diff <= {w_sum, r_shift[WIDTH:1]};
            ovf  <= w_sum ^ r_shift[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sub_tc_16_16_serial.md
Name: sub_tc_16_16_serial

Overview:
- Bit-serial two's-complement subtractor: diff = a - b, with a and b signed WIDTH-bit operands and a full-precision signed (WIDTH+1)-bit result.
- Computes one bit per clock, LSB first, as a + ~b + 1 using a single full-adder/borrow slice, trading latency for area.
- Sits in the arithmetic datapath alongside the combinational two's-complement adder and shares its width and sign conventions.
- Valid/ready handshakes on input and output let it sit between producer and consumer stages.

Parameters:
- WIDTH, 16, operand width in bits; result width is WIDTH+1. Legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block accepts operands; high only in IDLE
- a  input  WIDTH  signed minuend
- b  input  WIDTH  signed subtrahend
- out_valid  output  1  diff/ovf valid; high only in DONE
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH+1  signed result a - b, full precision
- ovf  output  1  result does not fit in signed WIDTH bits: diff[WIDTH] != diff[WIDTH-1]
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, diff=0, ovf=0, out_valid=0, busy=0.
  - Internal operand regs, bit counter and carry are cleared.
  - Reset wins over every other input on that edge, including mid-RUN or in DONE; the in-flight operation is discarded and no result is produced.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, and ~b sign-extended to WIDTH+1 bits; carry=1; bit counter=0; state -> RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge computes one sum bit and carry-out from sign-extended a bit i, inverted-b bit i and carry, for i = 0..WIDTH.
  - The bit is shifted into the result shift register MSB-first so that bit i ends up at diff[i].
  - After bit WIDTH is computed (WIDTH+1 RUN edges), diff and ovf are registered and state -> DONE.
  - The final carry-out is discarded; the sign extension guarantees the result is exact.
- Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge (17 for WIDTH=16).
- DONE:
  - out_valid=1.
  - diff and ovf are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: state -> IDLE and out_valid falls.
  - in_ready stays low in DONE, so a new accept happens at the earliest one edge after the result handshake.
  - Maximum throughput: one operation per WIDTH+3 cycles.
- diff and ovf may change only on the transition into DONE or on reset; no intermediate values appear on the diff port.
- Arithmetic:
  - diff equals the mathematical a - b for every operand pair.
  - Range: -2^WIDTH+1 .. 2^WIDTH-1, always representable in WIDTH+1 bits.
- Boundary cases:
  - a = b gives 0, ovf=0.
  - b = -2^(WIDTH-1): ~b+1 overflows in WIDTH bits, but the (WIDTH+1)-bit sign extension keeps the result exact.
  - out_ready held high continuously: DONE lasts exactly one cycle.
  - out_ready asserted while in IDLE or RUN has no effect.

Test Plan:
- Basic: a=5, b=3 -> after 17 cycles out_valid=1, diff=17'h00002, ovf=0. Then a=3, b=5 -> diff=17'h1FFFE (-2), ovf=0.
- Extremes: a=-32768, b=1 -> diff=17'h17FFF (-32769), ovf=1. a=32767, b=-32768 -> diff=17'h0FFFF (65535), ovf=1. a=b=-32768 -> diff=0, ovf=0.
- Back-pressure and ignored inputs:
  - Hold out_ready=0 for 10 cycles in DONE -> diff, ovf and out_valid stable throughout.
  - Toggle in_valid and change a/b during RUN and DONE -> no effect, in_ready=0 in both states.
- Reset mid-operation: assert rst at RUN cycle 8 -> next cycle state IDLE, out_valid=0, diff=0. A subsequent a=100, b=-50 gives diff=150.
- Random regression: 20 vectors from $random seeded with 1, out_ready=1.
  - Each diff is compared against a-b computed in 17-bit signed arithmetic.
  - ovf is compared against the out-of-16-bit-range check.
  - Accept-to-out_valid latency checked at exactly 17 cycles, and accept-to-next-accept spacing at 19 cycles.
